mac_tx_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one RMII transmit serializer (mac_tx, 2-bit, 8-bit byte interface) between N_REQ frame sources, e.g. the ARP responder and the UDP payload path.
- Grants one source per frame and hands the serializer the frame header fields.
- Streams the payload bytes, zero-pads short payloads to the Ethernet minimum, and enforces the inter-frame gap before the next grant.

---
 rtl/mac_tx_arb.sv | 156 +++++++++++++++
 tb/tb_mac_tx_arb.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_arb.sv
// Round-robin frame arbiter in front of the shared RMII transmit serializer.
// Grants one source per frame, streams and zero-pads its payload, then holds off for the IFG.

module mac_tx_arb_lane #(
    parameter int MIN_LEN = 46,
    parameter int MAX_LEN = 1500
) (
    input  logic [10:0] len,
    output logic        bad,
    output logic [10:0] plen
);
    assign bad  = (len == 11'd0) || (len > 11'(MAX_LEN));
    assign plen = (len < 11'(MIN_LEN)) ? 11'(MIN_LEN) : len;
endmodule

module mac_tx_arb #(
    parameter int N_REQ   = 2,
    parameter int MIN_LEN = 46,
    parameter int MAX_LEN = 1500,
    parameter int IFG_CYC = 48
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_REQ-1:0]    i_req,
    input  logic [N_REQ*11-1:0] i_len,
    input  logic [N_REQ*16-1:0] i_etype,
    input  logic [N_REQ*8-1:0]  i_data,
    output logic [N_REQ-1:0]    o_gnt,
    output logic [N_REQ-1:0]    o_rd,
    output logic [N_REQ-1:0]    o_err,
    output logic               o_tx_start,
    output logic [10:0]        o_tx_len,
    output logic [15:0]        o_tx_etype,
    output logic [7:0]         o_tx_data,
    input  logic               i_tx_rd,
    input  logic               i_tx_done,
    output logic               o_busy
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int FW = $clog2(IFG_CYC + 1);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    typedef enum logic [2:0] {IDLE, PAYLOAD, PAD, WAIT_DONE, IFG} state_t;

    state_t                   state;
    logic [IW-1:0]            last;
    logic [IW-1:0]            gidx;
    logic [IW-1:0]            win;
    logic                     win_vld;
    logic [10:0]              cnt;
    logic [10:0]              len_r;
    logic [FW-1:0]            ifg_cnt;
    logic [N_REQ-1:0]         lane_bad;
    logic [N_REQ-1:0][10:0]   lane_plen;

    for (genvar g = 0; g < N_REQ; g++) begin : g_lane
        mac_tx_arb_lane #(
            .MIN_LEN(MIN_LEN),
            .MAX_LEN(MAX_LEN)
        ) u_lane (
            .len  (i_len[g*11 +: 11]),
            .bad  (lane_bad[g]),
            .plen (lane_plen[g])
        );
    end

    // Scan from farthest to nearest after 'last' so the nearest requester is the final assignment.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (i_req[(int'(last) + k) % N_REQ]) begin
                win     = IW'((int'(last) + k) % N_REQ);
                win_vld = 1'b1;
            end
        end
    end

    assign o_busy    = (state != IDLE);
    assign o_rd      = (state == PAYLOAD && i_tx_rd) ? o_gnt : '0;
    assign o_tx_data = (state == PAYLOAD) ? i_data[gidx*8 +: 8] : 8'h00;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            last       <= IW'(N_REQ - 1);
            gidx       <= '0;
            cnt        <= '0;
            len_r      <= '0;
            ifg_cnt    <= '0;
            o_gnt      <= '0;
            o_err      <= '0;
            o_tx_start <= 1'b0;
            o_tx_len   <= '0;
            o_tx_etype <= '0;
        end else begin
            o_tx_start <= 1'b0;
            o_err      <= '0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        last <= win;
                        if (lane_bad[win]) begin
                            o_err <= ONE << win;
                        end else begin
                            o_gnt      <= ONE << win;
                            gidx       <= win;
                            o_tx_start <= 1'b1;
                            o_tx_len   <= lane_plen[win];
                            o_tx_etype <= i_etype[win*16 +: 16];
                            len_r      <= i_len[win*11 +: 11];
                            cnt        <= '0;
                            state      <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    // A done pulse here means the serializer aborted the frame.
                    if (i_tx_done) begin
                        ifg_cnt <= '0;
                        state   <= IFG;
                    end else if (i_tx_rd) begin
                        cnt <= cnt + 11'd1;
                        if (cnt == len_r - 11'd1)
                            state <= (len_r < 11'(MIN_LEN)) ? PAD : WAIT_DONE;
                    end
                end
                PAD: begin
                    if (i_tx_done) begin
                        ifg_cnt <= '0;
                        state   <= IFG;
                    end else if (i_tx_rd) begin
                        cnt <= cnt + 11'd1;
                        if (cnt == 11'(MIN_LEN - 1))
                            state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (i_tx_done) begin
                        ifg_cnt <= '0;
                        state   <= IFG;
                    end
                end
                IFG: begin
                    if (ifg_cnt == FW'(IFG_CYC - 1)) begin
                        o_gnt <= '0;
                        state <= IDLE;
                    end else begin
                        ifg_cnt <= ifg_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_tx_arb.sv
// Directed bench for mac_tx_arb: stimulus pushes expectations, a negedge monitor pops and compares.

module tb_mac_tx_arb;
    localparam int NR  = 2;
    localparam int IFG = 48;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req;
    logic [NR*11-1:0]  len;
    logic [NR*16-1:0]  etype;
    logic [NR*8-1:0]   data;
    logic [NR-1:0]     gnt, rd, err;
    logic              tx_start;
    logic [10:0]       tx_len;
    logic [15:0]       tx_etype;
    logic [7:0]        tx_data;
    logic              tx_rd, tx_done, busy;

    always #5 clk = ~clk;

    mac_tx_arb #(.N_REQ(NR), .MIN_LEN(46), .MAX_LEN(1500), .IFG_CYC(IFG)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_len(len), .i_etype(etype), .i_data(data),
        .o_gnt(gnt), .o_rd(rd), .o_err(err), .o_tx_start(tx_start), .o_tx_len(tx_len),
        .o_tx_etype(tx_etype), .o_tx_data(tx_data), .i_tx_rd(tx_rd), .i_tx_done(tx_done),
        .o_busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct { int idx; int len; int et; } start_t;
    typedef struct { logic [NR-1:0] rd; logic [7:0] d; } byte_t;
    start_t q_start[$];
    byte_t  q_byte[$];
    int     q_err[$];

    // Each requester presents a distinct byte sequence that advances on its read strobe.
    int ptr [NR] = '{default: 0};
    int sent[NR] = '{default: 0};

    function automatic logic [7:0] pat(input int r, input int p);
        return 8'((p + r * 64) & 255);
    endfunction

    for (genvar g = 0; g < NR; g++) begin : g_data
        assign data[g*8 +: 8] = pat(g, ptr[g]);
    end

    always @(posedge clk)
        for (int r = 0; r < NR; r++)
            if (rd[r]) ptr[r] <= ptr[r] + 1;

    always @(negedge clk) begin
        if (!rst) begin
            chk("gnt_onehot", 32'($onehot0(gnt)), 1);
            if (tx_rd) begin
                if (q_byte.size() == 0) chk("rd_unexpected", 0, 1);
                else begin
                    byte_t e;
                    e = q_byte.pop_front();
                    chk("o_rd", rd, e.rd);
                    chk("o_tx_data", tx_data, e.d);
                end
            end else begin
                chk("o_rd_no_tx_rd", rd, 0);
            end
            if (tx_start) begin
                if (q_start.size() == 0) chk("start_unexpected", 1, 0);
                else begin
                    start_t s;
                    s = q_start.pop_front();
                    chk("start_gnt", gnt, NR'(1) << s.idx);
                    chk("start_len", tx_len, s.len);
                    chk("start_etype", tx_etype, s.et);
                end
            end
            if (err != 0) begin
                if (q_err.size() == 0) chk("err_unexpected", err, 0);
                else chk("o_err", err, NR'(1) << q_err.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_start(input int idx, input int l, input int et);
        start_t s;
        s.idx = idx; s.len = l; s.et = et;
        q_start.push_back(s);
    endtask

    task automatic wait_start(input bit hold, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!tx_start && lat < 300);
        chk("start_seen", tx_start, 1);
        if (!hold) req = '0;
    endtask

    // Issue n serializer reads every 'gap' cycles; reads past l expect pad bytes.
    task automatic rd_bytes(input int r, input int l, input int gap, input int n);
        for (int i = 0; i < n; i++) begin
            byte_t e;
            repeat (gap - 1) tick();
            if (i < l) begin
                e.rd = NR'(1) << r;
                e.d  = pat(r, sent[r]);
                sent[r]++;
            end else begin
                e.rd = '0;
                e.d  = 8'h00;
            end
            q_byte.push_back(e);
            tx_rd = 1'b1;
            tick();
            tx_rd = 1'b0;
        end
    endtask

    task automatic finish(input bit ifg_rd);
        int k;
        byte_t e;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        k = 0;
        do begin
            if (ifg_rd && (k == 2 || k == 9)) begin
                e.rd = '0; e.d = 8'h00;
                q_byte.push_back(e);
                tx_rd = 1'b1;
            end
            tick();
            tx_rd = 1'b0;
            k++;
        end while (gnt != 0 && k < 200);
        chk("ifg_cycles", k, IFG);
        chk("busy_after_ifg", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        req = '0; len = '0; etype = '0; tx_rd = 1'b0; tx_done = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_gnt", gnt, 0);
        chk("rst_rd", rd, 0);
        chk("rst_err", err, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_len", tx_len, 0);
        chk("rst_etype", tx_etype, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_busy", busy, 0);

        // Single requester, 60 bytes, read every 4 cycles.
        len[10:0] = 11'd60; etype[15:0] = 16'h0800;
        push_start(0, 60, 16'h0800);
        req = 2'b01;
        wait_start(0, lat);
        chk("t1_latency", lat, 1);
        chk("t1_busy", busy, 1);
        rd_bytes(0, 60, 4, 60);
        repeat (3) tick();
        finish(0);

        // Short payload padded to 46; one extra read in WAIT_DONE is ignored.
        len[21:11] = 11'd10; etype[31:16] = 16'h0806;
        push_start(1, 46, 16'h0806);
        req = 2'b10;
        wait_start(0, lat);
        chk("t2_latency", lat, 1);
        rd_bytes(1, 10, 2, 46);
        chk("t2_busy", busy, 1);
        rd_bytes(1, 0, 1, 1);
        tick();
        finish(0);

        // Both requesters hold requests: grants alternate 0,1,0,1.
        len = {11'd47, 11'd50}; etype = {16'h2222, 16'h1111};
        req = 2'b11;
        for (int f = 0; f < 4; f++) begin
            int r, l;
            r = f % 2;
            l = (r == 1) ? 47 : 50;
            push_start(r, l, (r == 1) ? 16'h2222 : 16'h1111);
            wait_start(1, lat);
            chk("t3_latency", lat, 1);
            rd_bytes(r, l, 1, l);
            finish(0);
        end
        req = '0;

        // Bad lengths rejected in round-robin order with no frame started.
        len = {11'd1501, 11'd0};
        q_err.push_back(0);
        q_err.push_back(1);
        req = 2'b11;
        tick();
        chk("t4_err0", err, 2'b01);
        chk("t4_busy0", busy, 0);
        req[0] = 1'b0;
        tick();
        chk("t4_err1", err, 2'b10);
        chk("t4_busy1", busy, 0);
        req = '0;
        tick();
        chk("t4_err_clear", err, 0);
        chk("t4_busy2", busy, 0);
        len[21:11] = 11'd100;
        push_start(1, 100, 16'h2222);
        req = 2'b10;
        wait_start(0, lat);
        chk("t4_latency", lat, 1);
        rd_bytes(1, 100, 1, 100);
        tick();
        finish(0);

        // Reset in the middle of the payload, then pointer favours requester 0.
        len[10:0] = 11'd100;
        push_start(0, 100, 16'h1111);
        req = 2'b01;
        wait_start(0, lat);
        rd_bytes(0, 100, 1, 20);
        rst = 1'b1;
        tick();
        chk("t5_gnt", gnt, 0);
        chk("t5_busy", busy, 0);
        chk("t5_start", tx_start, 0);
        chk("t5_len", tx_len, 0);
        chk("t5_data", tx_data, 0);
        chk("t5_err", err, 0);
        rst = 1'b0;
        len[10:0] = 11'd46;
        push_start(0, 46, 16'h1111);
        req = 2'b11;
        wait_start(0, lat);
        chk("t5_latency", lat, 1);
        rd_bytes(0, 46, 1, 46);
        tick();
        finish(0);

        // Serializer abort after 5 of 100 bytes; reads during IFG get no strobe.
        push_start(1, 100, 16'h2222);
        req = 2'b10;
        wait_start(0, lat);
        rd_bytes(1, 100, 1, 5);
        finish(1);

        repeat (3) tick();
        chk("q_start_empty", q_start.size(), 0);
        chk("q_byte_empty", q_byte.size(), 0);
        chk("q_err_empty", q_err.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
